// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_t;

  // Source-ID header: tag in the upper 5 bits, requester index below.
  function automatic logic [7:0] hdr_byte(input logic [4:0] tag,
                                          input logic [2:0] id);
    return {tag, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first valid index
// after last_id_i, wrapping modulo N. The last owner has the lowest priority.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_id_i,
  output logic [IW-1:0] winner_o,
  output logic          any_valid_o
);

  logic [IW-1:0] cand;

  assign any_valid_o = |valid_i;

  // Walk from the farthest candidate back to the nearest so the nearest
  // valid index after last_id_i is the one left in winner_o.
  always_comb begin
    winner_o = '0;
    cand     = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_id_i) + k) % N);
      if (valid_i[cand]) winner_o = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one transmit-only UART between
// N_REQ byte-stream requesters. Optionally prefixes each packet with a
// source-ID header and aborts a packet whose owner stalls too long.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         N_REQ          = 4,
  parameter bit         HEADER_EN      = 1'b1,
  parameter logic [4:0] HEADER_TAG     = 5'b10100,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_wr_en_o,
  input  logic               tx_fifo_full_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CLG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CLG > 1) ? CLG : 1;
  localparam logic [CW-1:0] STALL_MAX =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    last_id_q, last_id_d;   // also the current owner while busy
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]    stall_q, stall_d;

  logic [IW-1:0]    winner;
  logic             any_valid;
  logic             xfer;
  logic             stall_hit;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .valid_i     (req_valid_i),
    .last_id_i   (last_id_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // A payload byte moves only when the owner offers one and the FIFO has room.
  assign xfer = (state_q == PAYLOAD) && req_valid_i[last_id_q] && !tx_fifo_full_i;

  // Stall limit reached; a zero timeout disables the abort entirely.
  assign stall_hit = (TIMEOUT_CYCLES != 0) && (stall_q == STALL_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_valid) state_d = HEADER_EN ? HEADER : PAYLOAD;
      end
      HEADER: begin
        if (!tx_fifo_full_i) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (xfer) begin
          if (req_last_i[last_id_q]) state_d = IDLE;
        end else if (stall_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: header byte in HEADER, pass-through of the owner's byte in PAYLOAD.
  always_comb begin
    req_ready_o = '0;
    tx_data_o   = '0;
    tx_wr_en_o  = 1'b0;
    timeout_o   = 1'b0;
    case (state_q)
      HEADER: begin
        tx_data_o  = hdr_byte(HEADER_TAG, 3'(last_id_q));
        tx_wr_en_o = !tx_fifo_full_i;
      end
      PAYLOAD: begin
        req_ready_o[last_id_q] = !tx_fifo_full_i;
        tx_data_o              = req_data_i[8*last_id_q +: 8];
        tx_wr_en_o             = xfer;
        timeout_o              = !xfer && stall_hit;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign grant_o = grant_q;

  // Owner/grant capture at arbitration and the payload stall counter.
  always_comb begin
    last_id_d = last_id_q;
    grant_d   = grant_q;
    stall_d   = stall_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          last_id_d       = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
        end
      end
      PAYLOAD: begin
        if (xfer || stall_hit) stall_d = '0;
        else                   stall_d = stall_q + 1'b1;
      end
      default: ;
    endcase
    // Grant is released together with the return to IDLE.
    if (state_d == IDLE) grant_d = '0;
  end

  // Datapath registers; last_id resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q <= IW'(N_REQ - 1);
      grant_q   <= '0;
      stall_q   <= '0;
    end else begin
      last_id_q <= last_id_d;
      grant_q   <= grant_d;
      stall_q   <= stall_d;
    end
  end

endmodule
